// File: rtl/ret_pred_check.sv
// ret_pred_check: checks return-address predictions against resolved jr targets.
// Predictions queue in order. Each resolution compares against the oldest entry.
// A mismatch redirects fetch and drops every younger, wrong-path prediction.
module ret_pred_check #(
    parameter int PC_WIDTH = 32,
    parameter int QSIZE    = 2
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                pred_valid,
    input  logic [PC_WIDTH-1:0] pred_addr,
    input  logic                res_valid,
    input  logic [PC_WIDTH-1:0] res_target,
    input  logic                flush,
    output logic                pred_ready,
    output logic                empty,
    output logic                full,
    output logic                mispredict,
    output logic [PC_WIDTH-1:0] redirect_pc,
    output logic                res_err,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         miss_cnt
);

    localparam int         DEPTH   = 2 ** QSIZE;
    localparam logic [QSIZE:0] DEPTH_C = (QSIZE+1)'(DEPTH);

    logic [PC_WIDTH-1:0] mem [DEPTH];
    logic [QSIZE-1:0]    rd_ptr, wr_ptr;
    logic [QSIZE:0]      occ;

    logic                has_res, hit, kill, push, pop;

    assign empty      = (occ == '0);
    assign full       = (occ == DEPTH_C);
    assign pred_ready = ~full;

    // A resolution only compares against a real queued entry. There is no
    // bypass from a same-cycle prediction.
    assign has_res = res_valid & ~empty;
    assign hit     = has_res & (mem[rd_ptr] == res_target);
    assign kill    = has_res & ~hit;
    assign push    = pred_valid & ~full & ~flush & ~kill;
    assign pop     = has_res & ~flush;

    // Prediction storage: written on push only, never reset (reads are gated by occ)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= pred_addr;
    end

    // Queue pointers and occupancy; flush or a mismatch empties the queue
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (flush || kill) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + QSIZE'(1);
            if (pop)  rd_ptr <= rd_ptr + QSIZE'(1);
            case ({push, pop})
                2'b10:   occ <= occ + (QSIZE+1)'(1);
                2'b01:   occ <= occ - (QSIZE+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Registered resolution outcome: one-cycle pulses; redirect_pc holds its value
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mispredict  <= 1'b0;
            res_err     <= 1'b0;
            redirect_pc <= '0;
        end else begin
            mispredict <= kill & ~flush;
            res_err    <= res_valid & empty & ~flush;
            if (kill && !flush) redirect_pc <= res_target;
        end
    end

    // Saturating hit/miss statistics, frozen during flush
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (!flush) begin
            if (hit  && hit_cnt  != 16'hFFFF) hit_cnt  <= hit_cnt  + 16'd1;
            if (kill && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ret_pred_check.sv
// Bench for ret_pred_check. It uses a table of directed single-cycle vectors
// with hand-computed results, then hand-written saturation and mid-stream
// reset sequences.
module tb_ret_pred_check;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        pred_valid, res_valid, flush;
    logic [31:0] pred_addr, res_target;
    logic        pred_ready, empty, full, mispredict, res_err;
    logic [31:0] redirect_pc;
    logic [15:0] hit_cnt, miss_cnt;

    int checks   = 0;
    int failures = 0;

    ret_pred_check #(.PC_WIDTH(32), .QSIZE(2)) dut (
        .clk(clk), .rst_b(rst_b),
        .pred_valid(pred_valid), .pred_addr(pred_addr),
        .res_valid(res_valid), .res_target(res_target), .flush(flush),
        .pred_ready(pred_ready), .empty(empty), .full(full),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .res_err(res_err),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pv;
        logic [31:0] pa;
        logic        rv;
        logic [31:0] rt;
        logic        fl;
        logic        e_empty;
        logic        e_full;
        logic        e_mis;
        logic [31:0] e_rpc;
        logic        e_err;
        logic [15:0] e_hit;
        logic [15:0] e_miss;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic pv, logic [31:0] pa, logic rv, logic [31:0] rt, logic fl,
                                logic ee, logic ef, logic em, logic [31:0] erpc, logic eerr,
                                logic [15:0] eh, logic [15:0] emi);
        vec_t v;
        v.pv = pv; v.pa = pa; v.rv = rv; v.rt = rt; v.fl = fl;
        v.e_empty = ee; v.e_full = ef; v.e_mis = em; v.e_rpc = erpc;
        v.e_err = eerr; v.e_hit = eh; v.e_miss = emi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [31:0] pa, input logic rv,
                         input logic [31:0] rt, input logic fl);
        pred_valid = pv; pred_addr = pa; res_valid = rv; res_target = rt; flush = fl;
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".empty"},       {31'd0, empty},      {31'd0, v.e_empty});
        chk({tag, ".full"},        {31'd0, full},       {31'd0, v.e_full});
        chk({tag, ".pred_ready"},  {31'd0, pred_ready}, {31'd0, ~v.e_full});
        chk({tag, ".mispredict"},  {31'd0, mispredict}, {31'd0, v.e_mis});
        chk({tag, ".redirect_pc"}, redirect_pc,         v.e_rpc);
        chk({tag, ".res_err"},     {31'd0, res_err},    {31'd0, v.e_err});
        chk({tag, ".hit_cnt"},     {16'd0, hit_cnt},    {16'd0, v.e_hit});
        chk({tag, ".miss_cnt"},    {16'd0, miss_cnt},   {16'd0, v.e_miss});
    endtask

    initial begin
        vec_t  rst_v;
        int    n;
        logic [31:0] base;
        logic [15:0] h;

        //           pv pa       rv rt       fl  emp ful mis rpc      err hit     miss
        // two pushes, two matching resolves
        tbl.push_back(mk(1, 32'h100, 0, 32'h0,   0,  0, 0, 0, 32'h0,   0, 16'd0, 16'd0));
        tbl.push_back(mk(1, 32'h200, 0, 32'h0,   0,  0, 0, 0, 32'h0,   0, 16'd0, 16'd0));
        tbl.push_back(mk(0, 32'h0,   1, 32'h100, 0,  0, 0, 0, 32'h0,   0, 16'd1, 16'd0));
        tbl.push_back(mk(0, 32'h0,   1, 32'h200, 0,  1, 0, 0, 32'h0,   0, 16'd2, 16'd0));
        // three pushes, mismatch clears the queue and redirects
        tbl.push_back(mk(1, 32'h100, 0, 32'h0,   0,  0, 0, 0, 32'h0,   0, 16'd2, 16'd0));
        tbl.push_back(mk(1, 32'h200, 0, 32'h0,   0,  0, 0, 0, 32'h0,   0, 16'd2, 16'd0));
        tbl.push_back(mk(1, 32'h300, 0, 32'h0,   0,  0, 0, 0, 32'h0,   0, 16'd2, 16'd0));
        tbl.push_back(mk(0, 32'h0,   1, 32'h104, 0,  1, 0, 1, 32'h104, 0, 16'd2, 16'd1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0,  1, 0, 0, 32'h104, 0, 16'd2, 16'd1));
        // fill to full, drop the fifth push, then wrap the pointers
        tbl.push_back(mk(1, 32'h10,  0, 32'h0,   0,  0, 0, 0, 32'h104, 0, 16'd2, 16'd1));
        tbl.push_back(mk(1, 32'h20,  0, 32'h0,   0,  0, 0, 0, 32'h104, 0, 16'd2, 16'd1));
        tbl.push_back(mk(1, 32'h30,  0, 32'h0,   0,  0, 0, 0, 32'h104, 0, 16'd2, 16'd1));
        tbl.push_back(mk(1, 32'h40,  0, 32'h0,   0,  0, 1, 0, 32'h104, 0, 16'd2, 16'd1));
        tbl.push_back(mk(1, 32'h99,  0, 32'h0,   0,  0, 1, 0, 32'h104, 0, 16'd2, 16'd1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h10,  0,  0, 0, 0, 32'h104, 0, 16'd3, 16'd1));
        tbl.push_back(mk(1, 32'h50,  1, 32'h20,  0,  0, 0, 0, 32'h104, 0, 16'd4, 16'd1));
        tbl.push_back(mk(1, 32'h60,  0, 32'h0,   0,  0, 1, 0, 32'h104, 0, 16'd4, 16'd1));
        // full at cycle start: pop accepted, push of 0x70 dropped
        tbl.push_back(mk(1, 32'h70,  1, 32'h30,  0,  0, 0, 0, 32'h104, 0, 16'd5, 16'd1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h40,  0,  0, 0, 0, 32'h104, 0, 16'd6, 16'd1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h50,  0,  0, 0, 0, 32'h104, 0, 16'd7, 16'd1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h60,  0,  1, 0, 0, 32'h104, 0, 16'd8, 16'd1));
        // resolve on empty queue (0x70 must not be there)
        tbl.push_back(mk(0, 32'h0,   1, 32'h70,  0,  1, 0, 0, 32'h104, 1, 16'd8, 16'd1));
        // empty queue with same-cycle prediction of the same address: no bypass
        tbl.push_back(mk(1, 32'h200, 1, 32'h200, 0,  0, 0, 0, 32'h104, 1, 16'd8, 16'd1));
        tbl.push_back(mk(0, 32'h0,   0, 32'h0,   0,  0, 0, 0, 32'h104, 0, 16'd8, 16'd1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h200, 0,  1, 0, 0, 32'h104, 0, 16'd9, 16'd1));
        // flush overrides a mismatching resolve and a push
        tbl.push_back(mk(1, 32'h1,   0, 32'h0,   0,  0, 0, 0, 32'h104, 0, 16'd9, 16'd1));
        tbl.push_back(mk(1, 32'h2,   0, 32'h0,   0,  0, 0, 0, 32'h104, 0, 16'd9, 16'd1));
        tbl.push_back(mk(1, 32'h3,   0, 32'h0,   0,  0, 0, 0, 32'h104, 0, 16'd9, 16'd1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h55,  1,  1, 0, 0, 32'h104, 0, 16'd9, 16'd1));
        tbl.push_back(mk(1, 32'h77,  0, 32'h0,   1,  1, 0, 0, 32'h104, 0, 16'd9, 16'd1));
        tbl.push_back(mk(0, 32'h0,   1, 32'h77,  0,  1, 0, 0, 32'h104, 1, 16'd9, 16'd1));

        // reset state
        rst_b = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0);
        #12;
        rst_v = mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 16'd0, 16'd0);
        chk_all("reset", rst_v);
        @(negedge clk);
        rst_b = 1'b1;

        // table: inputs driven on a falling edge, results checked on the next
        foreach (tbl[i]) begin
            drive(tbl[i].pv, tbl[i].pa, tbl[i].rv, tbl[i].rt, tbl[i].fl);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), tbl[i]);
        end

        // saturation: keep one entry queued, push and match every cycle
        h    = tbl[tbl.size()-1].e_hit;
        base = 32'h4000;
        n    = int'(16'hFFFE - h);
        drive(1, base, 0, 32'h0, 0);
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            drive(1, base + 32'(i) + 32'd1, 1, base + 32'(i), 0);
            @(negedge clk);
        end
        chk("sat.hit_fffe", {16'd0, hit_cnt}, 32'h0000FFFE);
        for (int i = n; i < n + 3; i++) begin
            drive(1, base + 32'(i) + 32'd1, 1, base + 32'(i), 0);
            @(negedge clk);
        end
        chk("sat.hit_ffff", {16'd0, hit_cnt}, 32'h0000FFFF);
        chk("sat.miss",     {16'd0, miss_cnt}, 32'd1);
        chk("sat.empty",    {31'd0, empty}, 32'd0);

        // mismatch against the queued entry, then reset while the pulse is up
        drive(0, 32'h0, 1, base + 32'(n) + 32'd3 + 32'd1, 0);
        @(negedge clk);
        drive(0, 32'h0, 0, 32'h0, 0);
        chk("mid.mispredict", {31'd0, mispredict}, 32'd1);
        chk("mid.miss",       {16'd0, miss_cnt},   32'd2);
        #2 rst_b = 1'b0;
        #1;
        chk_all("midrst", rst_v);
        @(negedge clk);
        chk_all("midrst_hold", rst_v);
        rst_b = 1'b1;
        @(negedge clk);
        chk_all("post_rst", rst_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
